// File: rtl/btn_debounce_pulse.sv
// btn_debounce_pulse: synchronized, debounced push-button with press/release strobes, auto-repeat and a press counter
//   clk, rst (async, active-high) | btn_in raw button | repeat_en enables auto-repeat
//   btn_level debounced level | btn_pulse press/repeat strobe | btn_release release strobe | press_count pulse tally
module btn_debounce_pulse #(
  parameter int DEB_CYCLES  = 1_000_000,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int REP_CYCLES  = 10_000_000,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  input  logic       repeat_en,
  output logic       btn_level,
  output logic       btn_pulse,
  output logic       btn_release,
  output logic [7:0] press_count
);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_RLD = CNT_W'(HOLD_CYCLES - REP_CYCLES);
  state_t state, state_nx;
  logic sync0, btn_s;
  logic [CNT_W-1:0] deb_cnt, deb_nx, hold_cnt, hold_nx;
  logic level_nx, pulse_nx, rel_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync0       <= 1'b0;
      btn_s       <= 1'b0;
      state       <= IDLE;
      deb_cnt     <= '0;
      hold_cnt    <= '0;
      btn_level   <= 1'b0;
      btn_pulse   <= 1'b0;
      btn_release <= 1'b0;
      press_count <= '0;
    end else begin
      sync0       <= btn_in;
      btn_s       <= sync0;
      state       <= state_nx;
      deb_cnt     <= deb_nx;
      hold_cnt    <= hold_nx;
      btn_level   <= level_nx;
      btn_pulse   <= pulse_nx;
      btn_release <= rel_nx;
      press_count <= press_count + 8'(pulse_nx);
    end
  // Hold counter freezes during RELEASE_WAIT so a bounced release resumes the repeat schedule.
  always_comb begin
    state_nx = state;
    deb_nx   = deb_cnt;
    hold_nx  = hold_cnt;
    level_nx = btn_level;
    pulse_nx = 1'b0;
    rel_nx   = 1'b0;
    case (state)
      IDLE:
        if (btn_s) begin
          state_nx = PRESS_WAIT;
          deb_nx   = '0;
        end
      PRESS_WAIT:
        if (!btn_s) state_nx = IDLE;
        else if (deb_cnt == DEB_MAX) begin
          state_nx = PRESSED;
          level_nx = 1'b1;
          pulse_nx = 1'b1;
          hold_nx  = '0;
        end else deb_nx = deb_cnt + 1'b1;
      PRESSED:
        if (!btn_s) begin
          state_nx = RELEASE_WAIT;
          deb_nx   = '0;
        end else if (hold_cnt != HOLD_MAX) hold_nx = hold_cnt + 1'b1;
        else if (repeat_en) begin
          pulse_nx = 1'b1;
          hold_nx  = HOLD_RLD;
        end
      RELEASE_WAIT:
        if (btn_s) state_nx = PRESSED;
        else if (deb_cnt == DEB_MAX) begin
          state_nx = IDLE;
          level_nx = 1'b0;
          rel_nx   = 1'b1;
        end else deb_nx = deb_cnt + 1'b1;
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_btn_debounce_pulse.sv
// tb_btn_debounce_pulse: randomized and directed checks of btn_debounce_pulse against a run-length reference model
module tb_btn_debounce_pulse;
  localparam int DEB = 4, HOLD = 20, REP = 5;
  logic clk = 0, rst = 1, btn_in = 0, repeat_en = 0;
  logic btn_level, btn_pulse, btn_release;
  logic [7:0] press_count;
  int tests = 0, fails = 0, edge_n = 0;
  logic d1, d2, m_lvl, m_pulse, m_rel;
  logic [7:0] m_cnt;
  int run, held, thr;
  wire [10:0] obs = {btn_level, btn_pulse, btn_release, press_count};

  btn_debounce_pulse #(.DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REP_CYCLES(REP), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .repeat_en(repeat_en),
    .btn_level(btn_level), .btn_pulse(btn_pulse), .btn_release(btn_release), .press_count(press_count));

  always #5 clk = ~clk;

  function automatic logic [10:0] exp_vec();
    return {m_lvl, m_pulse, m_rel, m_cnt};
  endfunction

  task automatic model_reset();
    d1 = 0; d2 = 0; m_lvl = 0; m_pulse = 0; m_rel = 0; m_cnt = 0;
    run = 0; held = 0; thr = HOLD;
  endtask

  // A level change is accepted once the synchronized input has disagreed with the
  // accepted level for DEB+1 consecutive edges; repeats fire after thr held edges.
  task automatic cyc(input logic b, input logic r);
    logic seen;
    @(negedge clk);
    btn_in = b; repeat_en = r;
    @(posedge clk);
    #1;
    edge_n++;
    seen = d2; d2 = d1; d1 = b;
    m_pulse = 0; m_rel = 0;
    if (seen != m_lvl) begin
      run++;
      if (run == DEB + 1) begin
        m_lvl = seen; run = 0;
        if (seen) begin m_pulse = 1; held = 0; thr = HOLD; end
        else m_rel = 1;
      end
    end else begin
      if (m_lvl && run == 0) begin
        held++;
        if (r && held >= thr) begin m_pulse = 1; held = 0; thr = REP; end
      end
      run = 0;
    end
    m_cnt += 8'(m_pulse);
  endtask

  task automatic settle();
    repeat (12) cyc(0, 0);
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (obs !== 11'd0) begin fails++; $display("FAIL reset_async: got %h expected 000", obs); end
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (obs !== 11'd0) begin fails++; $display("FAIL reset_clocked: got %h expected 000", obs); end
    @(negedge clk);
    rst = 0;
    model_reset();
    settle();
  endtask

  task automatic test_clean_press();
    int e0 = edge_n, first = -1, np = 0, rel_e = -1;
    for (int i = 0; i < 50; i++) begin
      cyc(i < 40, 0);
      tests++;
      if (obs !== exp_vec()) begin fails++; $display("FAIL clean_press cyc%0d: got %h expected %h", i, obs, exp_vec()); end
      if (btn_pulse) begin np++; if (first < 0) first = edge_n - e0; end
      if (btn_release) rel_e = edge_n - e0;
    end
    tests++;
    if (first != 7) begin fails++; $display("FAIL clean_press_edge: got %0d expected 7", first); end
    tests++;
    if (np != 1) begin fails++; $display("FAIL clean_press_count: got %0d expected 1", np); end
    tests++;
    if (rel_e != 47) begin fails++; $display("FAIL clean_release_edge: got %0d expected 47", rel_e); end
  endtask

  task automatic test_bounce();
    int e0 = edge_n, first = -1, np = 0;
    logic [3:0] pat = 4'b0101;
    for (int i = 0; i < 30; i++) begin
      cyc(i < 4 ? pat[i] : (i < 20), 0);
      tests++;
      if (obs !== exp_vec()) begin fails++; $display("FAIL bounce cyc%0d: got %h expected %h", i, obs, exp_vec()); end
      if (btn_pulse) begin np++; if (first < 0) first = edge_n - e0; end
    end
    tests++;
    if (first != 11 || np != 1) begin fails++; $display("FAIL bounce_pulse: got edge %0d n %0d expected edge 11 n 1", first, np); end
  endtask

  task automatic test_release_glitch();
    int np = 0, nr = 0;
    for (int i = 0; i < 36; i++) begin
      cyc(!(i == 20 || i == 21), 0);
      tests++;
      if (obs !== exp_vec()) begin fails++; $display("FAIL glitch cyc%0d: got %h expected %h", i, obs, exp_vec()); end
      np += btn_pulse; nr += btn_release;
    end
    tests++;
    if (np != 1 || nr != 0 || btn_level !== 1'b1) begin
      fails++; $display("FAIL glitch_summary: got pulses %0d releases %0d level %b expected 1 0 1", np, nr, btn_level);
    end
    settle();
  endtask

  task automatic test_auto_repeat();
    int e0 = edge_n, pe[$], re[$];
    int exp_pe[7] = '{7, 27, 32, 37, 42, 47, 52};
    logic [7:0] c0 = press_count;
    for (int i = 0; i < 64; i++) begin
      cyc(i < 50, 1);
      tests++;
      if (obs !== exp_vec()) begin fails++; $display("FAIL repeat cyc%0d: got %h expected %h", i, obs, exp_vec()); end
      if (btn_pulse) pe.push_back(edge_n - e0);
      if (btn_release) re.push_back(edge_n - e0);
    end
    tests++;
    if (pe.size() != 7) begin fails++; $display("FAIL repeat_npulses: got %0d expected 7", pe.size()); end
    for (int i = 0; i < 7 && i < pe.size(); i++) begin
      tests++;
      if (pe[i] != exp_pe[i]) begin fails++; $display("FAIL repeat_edge%0d: got %0d expected %0d", i, pe[i], exp_pe[i]); end
    end
    tests++;
    if (re.size() != 1 || (re.size() == 1 && re[0] != 57)) begin
      fails++; $display("FAIL repeat_release: got n %0d expected one release at edge 57", re.size());
    end
    tests++;
    if (press_count !== 8'(c0 + 8'd7)) begin fails++; $display("FAIL repeat_count: got %0d expected %0d", press_count, 8'(c0 + 8'd7)); end
  endtask

  task automatic test_wrap();
    @(posedge clk);
    #2 rst = 1;
    @(posedge clk);
    #2 rst = 0;
    model_reset();
    for (int p = 0; p < 256; p++) begin
      for (int i = 0; i < 16; i++) begin
        cyc(i < 8, 0);
        tests++;
        if (obs !== exp_vec()) begin fails++; $display("FAIL wrap p%0d c%0d: got %h expected %h", p, i, obs, exp_vec()); end
      end
      if (p == 254) begin
        tests++;
        if (press_count !== 8'd255) begin fails++; $display("FAIL wrap_255: got %0d expected 255", press_count); end
      end
    end
    tests++;
    if (press_count !== 8'd0) begin fails++; $display("FAIL wrap_zero: got %0d expected 0", press_count); end
  endtask

  task automatic test_reset_mid();
    int e0, first = -1;
    for (int i = 0; i < 12; i++) cyc(1, 0);
    tests++;
    if (btn_level !== 1'b1) begin fails++; $display("FAIL mid_pressed: got level %b expected 1", btn_level); end
    @(posedge clk);
    #3 rst = 1;
    #1;
    tests++;
    if (obs !== 11'd0) begin fails++; $display("FAIL mid_reset_async: got %h expected 000", obs); end
    repeat (2) @(posedge clk);
    #2 rst = 0;
    model_reset();
    e0 = edge_n;
    for (int i = 0; i < 12; i++) begin
      cyc(1, 0);
      tests++;
      if (obs !== exp_vec()) begin fails++; $display("FAIL mid_after cyc%0d: got %h expected %h", i, obs, exp_vec()); end
      if (btn_pulse && first < 0) first = edge_n - e0;
    end
    tests++;
    if (first != 7) begin fails++; $display("FAIL mid_fresh_edge: got %0d expected 7", first); end
    settle();
  endtask

  task automatic test_random();
    logic b = 0, r = 0, pp = 0;
    int len = 0;
    for (int i = 0; i < 3000; i++) begin
      if (len == 0) begin
        b = ~b;
        len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 45);
        if ($urandom_range(0, 4) == 0) r = ~r;
      end
      len--;
      if ($urandom_range(0, 40) == 0) r = ~r;
      cyc(b, r);
      tests++;
      if (obs !== exp_vec()) begin fails++; $display("FAIL random cyc%0d: got %h expected %h", i, obs, exp_vec()); end
      tests++;
      if ((btn_pulse && btn_release) || (btn_pulse && pp)) begin
        fails++; $display("FAIL strobe_shape cyc%0d: got pulse %b release %b prev %b expected isolated strobes", i, btn_pulse, btn_release, pp);
      end
      pp = btn_pulse;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_press();
    settle();
    test_bounce();
    settle();
    test_release_glitch();
    test_auto_repeat();
    settle();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
